// File: rtl/ip_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ip_pkg                                                 |
// | Description : Shared IPv4 constants, TX state type, checksum fold.   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package ip_pkg;

  localparam int IP_HDR_BYTES = 20;
  localparam int IP_VERSION   = 4;
  localparam int IP_IHL       = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CSUM    = 3'd1,
    ST_HEADER  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_DRAIN   = 3'd4
  } ip_tx_state_t;

  // Two end-around folds cover any 20-bit sum of nine 16-bit words.
  function automatic logic [15:0] ip_csum_fold(input logic [19:0] sum);
    logic [16:0] s1;
    logic [16:0] s2;
    s1 = {1'b0, sum[15:0]} + {13'd0, sum[19:16]};
    s2 = {1'b0, s1[15:0]} + {16'd0, s1[16]};
    return ~s2[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ip_checksum_calc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ip_checksum_calc                                       |
// | Description : Two-cycle IPv4 header checksum (sum, then fold).       |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module ip_checksum_calc
  import ip_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [8:0][15:0] words,
  output logic [15:0]      csum,
  output logic             done
);

  logic [19:0] w_sum;
  logic [19:0] r_sum;
  logic        r_valid;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 9; i++) begin
      w_sum = w_sum + {4'd0, words[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= start;
      if (start) begin
        r_sum <= w_sum;
      end
    end
  end

  assign csum = ip_csum_fold(r_sum);
  assign done = r_valid;

endmodule
`default_nettype wire

// File: rtl/ip_tx_header_framer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ip_tx_header_framer                                    |
// | Description : Prepends a checksummed IPv4 header to a payload stream.|
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module ip_tx_header_framer
  import ip_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_hdr_valid,
  output logic        s_hdr_ready,
  input  logic [5:0]  s_dscp,
  input  logic [1:0]  s_ecn,
  input  logic [15:0] s_length,
  input  logic [15:0] s_identification,
  input  logic [2:0]  s_flags,
  input  logic [12:0] s_fragment_offset,
  input  logic [7:0]  s_ttl,
  input  logic [7:0]  s_protocol,
  input  logic [31:0] s_source_ip,
  input  logic [31:0] s_dest_ip,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        err_short,
  output logic        err_long,
  output logic        err_bad_length
);

  localparam logic [15:0] c_hdr_len   = 16'(IP_HDR_BYTES);
  localparam logic [4:0]  c_last_byte = 5'(IP_HDR_BYTES - 1);

  ip_tx_state_t r_state, w_state_next;

  logic        r_alive, r_drain_zero;
  logic [5:0]  r_dscp;
  logic [1:0]  r_ecn;
  logic [15:0] r_length, r_id, r_pay_len, r_pay_cnt, r_csum;
  logic [2:0]  r_flags;
  logic [12:0] r_frag;
  logic [7:0]  r_ttl, r_proto;
  logic [31:0] r_src, r_dst;
  logic [4:0]  r_byte_cnt;
  logic [7:0]  r_tdata;
  logic        r_tvalid, r_tlast;
  logic        r_err_short, r_err_long, r_err_bad;

  logic             w_out_free, w_hdr_accept, w_beat, w_beat_last;
  logic [7:0]       w_beat_data, w_hdr_byte;
  logic             w_err_short, w_err_long, w_err_bad, w_s_tready;
  logic             w_csum_start, w_csum_done;
  logic [15:0]      w_csum, w_pay_cnt_next;
  logic [8:0][15:0] w_words;

  assign w_out_free     = !r_tvalid || m_axis_tready;
  assign w_pay_cnt_next = r_pay_cnt + 16'd1;

  assign w_words[0] = {4'(IP_VERSION), 4'(IP_IHL), r_dscp, r_ecn};
  assign w_words[1] = r_length;
  assign w_words[2] = r_id;
  assign w_words[3] = {r_flags, r_frag};
  assign w_words[4] = {r_ttl, r_proto};
  assign w_words[5] = r_src[31:16];
  assign w_words[6] = r_src[15:0];
  assign w_words[7] = r_dst[31:16];
  assign w_words[8] = r_dst[15:0];

  ip_checksum_calc u_csum (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_csum_start),
    .words (w_words),
    .csum  (w_csum),
    .done  (w_csum_done)
  );

  always_comb begin
    w_hdr_byte = 8'h00;
    case (r_byte_cnt)
      5'd0:    w_hdr_byte = {4'(IP_VERSION), 4'(IP_IHL)};
      5'd1:    w_hdr_byte = {r_dscp, r_ecn};
      5'd2:    w_hdr_byte = r_length[15:8];
      5'd3:    w_hdr_byte = r_length[7:0];
      5'd4:    w_hdr_byte = r_id[15:8];
      5'd5:    w_hdr_byte = r_id[7:0];
      5'd6:    w_hdr_byte = {r_flags, r_frag[12:8]};
      5'd7:    w_hdr_byte = r_frag[7:0];
      5'd8:    w_hdr_byte = r_ttl;
      5'd9:    w_hdr_byte = r_proto;
      5'd10:   w_hdr_byte = r_csum[15:8];
      5'd11:   w_hdr_byte = r_csum[7:0];
      5'd12:   w_hdr_byte = r_src[31:24];
      5'd13:   w_hdr_byte = r_src[23:16];
      5'd14:   w_hdr_byte = r_src[15:8];
      5'd15:   w_hdr_byte = r_src[7:0];
      5'd16:   w_hdr_byte = r_dst[31:24];
      5'd17:   w_hdr_byte = r_dst[23:16];
      5'd18:   w_hdr_byte = r_dst[15:8];
      5'd19:   w_hdr_byte = r_dst[7:0];
      default: w_hdr_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_hdr_accept = 1'b0;
    w_beat       = 1'b0;
    w_beat_data  = 8'h00;
    w_beat_last  = 1'b0;
    w_err_short  = 1'b0;
    w_err_long   = 1'b0;
    w_err_bad    = 1'b0;
    w_s_tready   = 1'b0;
    w_csum_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (s_hdr_valid && r_alive) begin
          w_hdr_accept = 1'b1;
          if (s_length < c_hdr_len) begin
            w_err_bad    = 1'b1;
            w_state_next = ST_DRAIN;
          end else begin
            w_state_next = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        w_csum_start = !w_csum_done;
        if (w_csum_done) w_state_next = ST_HEADER;
      end
      ST_HEADER: begin
        if (w_out_free) begin
          w_beat      = 1'b1;
          w_beat_data = w_hdr_byte;
          if (r_byte_cnt == c_last_byte) begin
            if (r_pay_len == 16'd0) begin
              w_beat_last  = 1'b1;
              w_state_next = ST_DRAIN;
            end else begin
              w_state_next = ST_PAYLOAD;
            end
          end
        end
      end
      ST_PAYLOAD: begin
        w_s_tready = w_out_free;
        if (s_axis_tvalid && w_out_free) begin
          w_beat      = 1'b1;
          w_beat_data = s_axis_tdata;
          if (w_pay_cnt_next == r_pay_len) begin
            w_beat_last = 1'b1;
            if (s_axis_tlast) begin
              w_state_next = ST_IDLE;
            end else begin
              w_err_long   = 1'b1;
              w_state_next = ST_DRAIN;
            end
          end else if (s_axis_tlast) begin
            w_beat_last  = 1'b1;
            w_err_short  = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        // Header-only frames have no payload to discard; just let the tlast beat go.
        if (r_drain_zero) begin
          if (w_out_free) w_state_next = ST_IDLE;
        end else begin
          w_s_tready = 1'b1;
          if (s_axis_tvalid && s_axis_tlast) w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alive      <= 1'b0;
      r_drain_zero <= 1'b0;
      r_dscp       <= '0;
      r_ecn        <= '0;
      r_length     <= '0;
      r_id         <= '0;
      r_flags      <= '0;
      r_frag       <= '0;
      r_ttl        <= '0;
      r_proto      <= '0;
      r_src        <= '0;
      r_dst        <= '0;
      r_pay_len    <= '0;
      r_pay_cnt    <= '0;
      r_csum       <= '0;
      r_byte_cnt   <= '0;
      r_tdata      <= '0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_err_short  <= 1'b0;
      r_err_long   <= 1'b0;
      r_err_bad    <= 1'b0;
    end else begin
      r_alive     <= 1'b1;
      r_err_short <= w_err_short;
      r_err_long  <= w_err_long;
      r_err_bad   <= w_err_bad;
      if (w_hdr_accept) begin
        r_dscp       <= s_dscp;
        r_ecn        <= s_ecn;
        r_length     <= s_length;
        r_id         <= s_identification;
        r_flags      <= s_flags;
        r_frag       <= s_fragment_offset;
        r_ttl        <= s_ttl;
        r_proto      <= s_protocol;
        r_src        <= s_source_ip;
        r_dst        <= s_dest_ip;
        r_pay_len    <= s_length - c_hdr_len;
        r_pay_cnt    <= '0;
        r_byte_cnt   <= '0;
        r_drain_zero <= 1'b0;
      end else begin
        if (r_state == ST_HEADER && w_beat) r_byte_cnt <= r_byte_cnt + 5'd1;
        if (r_state == ST_PAYLOAD && w_beat) r_pay_cnt <= w_pay_cnt_next;
        if (r_state == ST_HEADER && w_beat_last) r_drain_zero <= 1'b1;
      end
      if (r_state == ST_CSUM && w_csum_done) r_csum <= w_csum;
      if (w_out_free) begin
        r_tvalid <= w_beat;
        r_tlast  <= w_beat_last;
        if (w_beat) r_tdata <= w_beat_data;
      end
    end
  end

  assign s_hdr_ready    = (r_state == ST_IDLE) && r_alive;
  assign s_axis_tready  = w_s_tready;
  assign m_axis_tdata   = r_tdata;
  assign m_axis_tvalid  = r_tvalid;
  assign m_axis_tlast   = r_tlast;
  assign err_short      = r_err_short;
  assign err_long       = r_err_long;
  assign err_bad_length = r_err_bad;

endmodule
`default_nettype wire

// File: tb/tb_ip_tx_header_framer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ip_tx_header_framer                                 |
// | Description : Scoreboard bench with a frame-level reference model.   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_ip_tx_header_framer;

  typedef struct {
    logic [5:0]  dscp;
    logic [1:0]  ecn;
    logic [15:0] len;
    logic [15:0] id;
    logic [2:0]  flags;
    logic [12:0] frag;
    logic [7:0]  ttl;
    logic [7:0]  proto;
    logic [31:0] src;
    logic [31:0] dst;
  } hdr_t;
  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_hdr_valid, s_hdr_ready;
  logic [5:0]  s_dscp;
  logic [1:0]  s_ecn;
  logic [15:0] s_length, s_identification;
  logic [2:0]  s_flags;
  logic [12:0] s_fragment_offset;
  logic [7:0]  s_ttl, s_protocol;
  logic [31:0] s_source_ip, s_dest_ip;
  logic [7:0]  s_axis_tdata, m_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic        err_short, err_long, err_bad_length;

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] exp_q[$];
  logic [2:0] err_q[$];   // {short, long, bad_length}
  bit mon_en = 1'b1, stall_mode = 1'b0, gap_mode = 1'b0, nostall_chk = 1'b0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ip_tx_header_framer dut (
    .clk(clk), .rst_n(rst_n),
    .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready),
    .s_dscp(s_dscp), .s_ecn(s_ecn), .s_length(s_length),
    .s_identification(s_identification), .s_flags(s_flags),
    .s_fragment_offset(s_fragment_offset), .s_ttl(s_ttl), .s_protocol(s_protocol),
    .s_source_ip(s_source_ip), .s_dest_ip(s_dest_ip),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .err_short(err_short), .err_long(err_long), .err_bad_length(err_bad_length)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  always @(posedge clk) begin
    #1;
    m_axis_tready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Monitor: compares every transferred beat and every error pulse against the queues.
  logic       prev_stall = 1'b0;
  logic [8:0] prev_beat;
  int         beat_idx = 0;
  int         first_cyc = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      beat_idx   = 0;
    end else if (mon_en) begin
      if (prev_stall)
        check("hold_stable", {22'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {22'd0, 1'b1, prev_beat});
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tlast, m_axis_tdata};
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) fail_now("beat", $sformatf("got unexpected beat %0h, expected none", {m_axis_tlast, m_axis_tdata}));
        else check("beat", {23'd0, m_axis_tlast, m_axis_tdata}, {23'd0, exp_q.pop_front()});
        if (beat_idx == 0) first_cyc = cyc;
        beat_idx++;
        if (m_axis_tlast) begin
          if (nostall_chk) check("frame_span", cyc - first_cyc + 1, beat_idx);
          beat_idx = 0;
        end
      end
      if (err_short || err_long || err_bad_length) begin
        if (err_q.size() == 0) fail_now("err", $sformatf("got pulse %0b, expected none", {err_short, err_long, err_bad_length}));
        else check("err", {29'd0, err_short, err_long, err_bad_length}, {29'd0, err_q.pop_front()});
      end
    end
  end

  // Reference model: what the frame should look like, computed from the header rules.
  task automatic model(input hdr_t h, input bq_t p);
    logic [159:0] hv;
    logic [31:0]  sum;
    int pl, emit;
    if (h.len < 16'd20) begin
      err_q.push_back(3'b001);
      return;
    end
    hv = {8'h45, h.dscp, h.ecn, h.len, h.id, h.flags, h.frag, h.ttl, h.proto, 16'h0000, h.src, h.dst};
    sum = 0;
    for (int i = 0; i < 10; i++) sum = sum + {16'd0, hv[159 - 16*i -: 16]};
    while (sum > 32'h0000_ffff) sum = (sum & 32'h0000_ffff) + (sum >> 16);
    hv[79:64] = ~sum[15:0];
    pl = int'(h.len) - 20;
    for (int i = 0; i < 20; i++) exp_q.push_back({(pl == 0 && i == 19), hv[159 - 8*i -: 8]});
    if (pl == 0) return;
    emit = (p.size() < pl) ? p.size() : pl;
    for (int i = 0; i < emit; i++) exp_q.push_back({(i == emit - 1), p[i]});
    if (p.size() < pl) err_q.push_back(3'b100);
    else if (p.size() > pl) err_q.push_back(3'b010);
  endtask

  task automatic issue_desc(input hdr_t h, output bit ok);
    s_dscp = h.dscp; s_ecn = h.ecn; s_length = h.len; s_identification = h.id;
    s_flags = h.flags; s_fragment_offset = h.frag; s_ttl = h.ttl; s_protocol = h.proto;
    s_source_ip = h.src; s_dest_ip = h.dst;
    s_hdr_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk);
      if (s_hdr_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      fail_now("desc_accept", "s_hdr_ready stayed 0, expected 1");
      s_hdr_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s_hdr_valid = 1'b0;
  endtask

  task automatic send_frame(input hdr_t h, input bq_t p, input bit lat_chk, input bit golden);
    bit ok;
    logic [159:0] g;
    model(h, p);
    if (golden) begin
      g = 160'h45000073_00004000_4011B861_C0A80001_C0A800C7;
      for (int i = 0; i < 20; i++) exp_q[i] = {1'b0, g[159 - 8*i -: 8]};
    end
    issue_desc(h, ok);
    if (!ok) return;
    if (lat_chk) begin
      repeat (3) @(negedge clk);
      check("lat_before", {31'd0, m_axis_tvalid}, 32'd0);
      @(negedge clk);
      check("lat_byte0", {23'd0, m_axis_tvalid, m_axis_tdata}, {23'd0, 1'b1, 8'h45});
      @(posedge clk); #1;
    end
    for (int i = 0; i < p.size(); i++) begin
      if (gap_mode && $urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
      s_axis_tdata = p[i]; s_axis_tlast = (i == p.size() - 1); s_axis_tvalid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 5000; t++) begin
        @(negedge clk);
        if (s_axis_tready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0;
      if (!ok) begin fail_now("payload_accept", "s_axis_tready stayed 0, expected 1"); break; end
    end
    for (int t = 0; t < 5000 && exp_q.size() != 0; t++) @(negedge clk);
    if (exp_q.size() != 0) begin
      fail_now("frame_done", $sformatf("%0d beats still missing, expected 0", exp_q.size()));
      exp_q.delete();
    end
    @(posedge clk); @(negedge clk);
    check("hdr_ready_after", {31'd0, s_hdr_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  function automatic hdr_t golden_hdr();
    hdr_t h;
    h.dscp = 0; h.ecn = 0; h.len = 16'h0073; h.id = 0; h.flags = 3'b010; h.frag = 0;
    h.ttl = 8'h40; h.proto = 8'h11; h.src = 32'hC0A80001; h.dst = 32'hC0A800C7;
    return h;
  endfunction

  function automatic hdr_t rand_hdr(input int len);
    hdr_t h;
    h.dscp = 6'($urandom); h.ecn = 2'($urandom); h.len = 16'(len); h.id = 16'($urandom);
    h.flags = 3'($urandom); h.frag = 13'($urandom); h.ttl = 8'($urandom); h.proto = 8'($urandom);
    h.src = $urandom; h.dst = $urandom;
    return h;
  endfunction

  function automatic bq_t rand_payload(input int n);
    bq_t p;
    for (int i = 0; i < n; i++) p.push_back(8'($urandom));
    return p;
  endfunction

  initial begin
    hdr_t h;
    bq_t  p;
    bit   ok;
    int   len, pl, n;
    rst_n = 1'b0; s_hdr_valid = 0; s_dscp = 0; s_ecn = 0; s_length = 0; s_identification = 0;
    s_flags = 0; s_fragment_offset = 0; s_ttl = 0; s_protocol = 0; s_source_ip = 0; s_dest_ip = 0;
    s_axis_tdata = 0; s_axis_tvalid = 0; s_axis_tlast = 0; m_axis_tready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {19'd0, s_hdr_ready, s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata,
                            err_short, err_long, err_bad_length}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("hdr_ready_after_reset", {31'd0, s_hdr_ready}, 32'd1);
    @(posedge clk); #1;

    // Golden frame, no stalls: latency, exact header bytes, back-to-back span.
    nostall_chk = 1'b1;
    send_frame(golden_hdr(), rand_payload(95), 1'b1, 1'b1);
    nostall_chk = 1'b0;

    stall_mode = 1'b1; gap_mode = 1'b1;
    send_frame(rand_hdr(64), rand_payload(44), 1'b0, 1'b0);
    send_frame(rand_hdr(40), rand_payload(10), 1'b0, 1'b0);
    send_frame(rand_hdr(24), rand_payload(8), 1'b0, 1'b0);
    send_frame(rand_hdr(10), rand_payload(5), 1'b0, 1'b0);
    p.delete();
    send_frame(rand_hdr(20), p, 1'b0, 1'b0);

    for (int k = 0; k < 14; k++) begin
      stall_mode = $urandom_range(0, 1); gap_mode = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0) begin
        len = $urandom_range(0, 19); n = $urandom_range(1, 6);
      end else begin
        len = $urandom_range(20, 80); pl = len - 20;
        case ($urandom_range(0, 2))
          0:       n = pl;
          1:       n = (pl > 1) ? $urandom_range(1, pl - 1) : pl;
          default: n = (pl > 0) ? $urandom_range(pl + 1, pl + 6) : 0;
        endcase
      end
      send_frame(rand_hdr(len), rand_payload(n), 1'b0, 1'b0);
    end

    // Reset in the middle of the header, then a clean golden frame.
    stall_mode = 1'b0; gap_mode = 1'b0; mon_en = 1'b0;
    @(posedge clk); #1;
    issue_desc(golden_hdr(), ok);
    if (ok) begin
      repeat (11) @(negedge clk);
      check("pre_reset_byte7", {23'd0, m_axis_tvalid, m_axis_tdata}, {23'd0, 1'b1, 8'h00});
      #2 rst_n = 1'b0;
      #1 check("reset_async_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
    mon_en = 1'b1;
    @(posedge clk); #1;
    nostall_chk = 1'b1;
    send_frame(golden_hdr(), rand_payload(95), 1'b1, 1'b1);
    nostall_chk = 1'b0;

    repeat (5) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    check("err_queue_empty", err_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ip_tx_header_framer.md
# ip_tx_header_framer

Transmit-side IPv4 framer that sits between FPGA user logic and the Ethernet MAC/ARP transmit path, opposite the receive-side IP header parser. It accepts one IP header descriptor plus a byte-wide payload stream. It emits a byte stream containing:
- a 20-byte IPv4 header, with version 4 and IHL 5 fixed and the header checksum computed in-block;
- the payload, trimmed or terminated to match the `length` field.

## Interface
Parameters: none.

- `clk` input 1: single clock, all logic rising-edge.
- `rst_n` input 1: asynchronous active-low reset.
- `s_hdr_valid` input 1: header descriptor valid.
- `s_hdr_ready` output 1: block can accept a descriptor.
- `s_dscp` input 6, `s_ecn` input 2: TOS fields.
- `s_length` input 16: IP total length, in bytes, header included.
- `s_identification` input 16.
- `s_flags` input 3.
- `s_fragment_offset` input 13.
- `s_ttl` input 8.
- `s_protocol` input 8.
- `s_source_ip` input 32.
- `s_dest_ip` input 32.
- `s_axis_tdata` input 8, `s_axis_tvalid` input 1, `s_axis_tready` output 1, `s_axis_tlast` input 1: payload in.
- `m_axis_tdata` output 8, `m_axis_tvalid` output 1, `m_axis_tready` input 1, `m_axis_tlast` output 1: framed IP packet out.
- `err_short` output 1: one-cycle pulse, payload ended before `length - 20` bytes.
- `err_long` output 1: one-cycle pulse, payload exceeded `length - 20` bytes.
- `err_bad_length` output 1: one-cycle pulse, `s_length < 20`.

## Operation
- States: IDLE, CSUM, HEADER, PAYLOAD, DRAIN.
- IDLE:
  - `s_hdr_ready` = 1.
  - On `s_hdr_valid && s_hdr_ready`, latch all fields and compute `pay_len = s_length - 20`.
  - If `s_length < 20`: pulse `err_bad_length` and go to DRAIN.
  - Otherwise go to CSUM.
- CSUM (2 cycles):
  - Cycle 1: 20-bit sum of the nine header words, checksum word = 0.
  - Cycle 2: fold carries twice and invert. Store the result as `csum`, then go to HEADER.
- HEADER:
  - Emit bytes 0..19 in network order: 0x45, {dscp,ecn}, length[15:8], length[7:0], id hi/lo, {flags,frag[12:8]}, frag[7:0], ttl, protocol, csum hi/lo, src[31:0] MSB first, dst[31:0] MSB first.
  - A 5-bit byte counter advances only on an output-register load.
  - After byte 19, go to PAYLOAD. If `pay_len == 0`, instead set `tlast` on byte 19 and go to DRAIN.
- PAYLOAD:
  - `s_axis_tready = !m_axis_tvalid || m_axis_tready`. Each input beat is copied to the output register and a 16-bit payload counter increments.
  - When the counter reaches `pay_len` with `s_axis_tlast = 1`: output `tlast`, return to IDLE.
  - When the counter reaches `pay_len` with `s_axis_tlast = 0`: output `tlast`, pulse `err_long`, go to DRAIN.
  - When `s_axis_tlast = 1` arrives before the counter reaches `pay_len`: output `tlast`, pulse `err_short`, return to IDLE. The short frame is emitted; no padding.
- DRAIN:
  - `s_axis_tready = 1`, input bytes are discarded.
  - On an accepted beat with `tlast`, return to IDLE.
  - Exception: a DRAIN entered from the `pay_len == 0` path does not drain and returns to IDLE immediately once the output byte is accepted.
- `s_hdr_ready` = 0 outside IDLE. Descriptors are never queued.

## Timing
- Output register rule: load when `!m_axis_tvalid || m_axis_tready`. `m_axis_tdata`, `tvalid` and `tlast` hold stable while `tvalid && !tready`.
- With a hold-free sink (`m_axis_tready` = 1), throughput is one byte per cycle.
- Latency: descriptor accepted at edge N; header byte 0 is presented with `m_axis_tvalid` = 1 after edge N+3.
- A frame of `length` L occupies L consecutive output beats when the sink never stalls and the payload source is never idle.
- Back-to-back frames: a new descriptor is accepted in the cycle after the last output beat is loaded. Minimum gap is 3 cycles idle on `m_axis`.
- Reset values:
  - All outputs 0, including `s_hdr_ready` and `s_axis_tready`; state IDLE.
  - `s_hdr_ready` rises on the first cycle after reset release.
- Reset mid-frame: the frame is abandoned, `m_axis_tvalid` drops immediately (asynchronously), and there is no `tlast`.
- Error pulses are registered, one cycle wide, and coincide with loading the affected `tlast` beat (or with the header accept for `err_bad_length`).

## Structure
- Package `ip_pkg`:
  - `IP_HDR_BYTES = 20`, `IP_VERSION = 4`, `IP_IHL = 5`.
  - State typedef `ip_tx_state_t`.
  - A function computing the one's-complement fold.
- Sub-module `ip_checksum_calc`: the 2-cycle pipelined header checksum. Inputs: the nine words and a start strobe. Outputs: the 16-bit checksum and a done strobe.

## Test plan
- Golden header. Stimulus: dscp 0, ecn 0, length 0x0073, id 0, flags 3'b010, frag 0, ttl 0x40, proto 0x11, src C0A80001, dst C0A800C7, 95 payload bytes. Response: header bytes 45 00 00 73 00 00 40 00 40 11 B8 61 C0 A8 00 01 C0 A8 00 C7, then the 95 bytes, `tlast` on beat 115, no error pulses.
- Random `m_axis_tready` stalls and random `s_axis_tvalid` gaps, length 64: output byte sequence identical to the no-stall case; data held stable while stalled.
- Short payload, length 40 with `tlast` on payload byte 10: 30 output beats, `tlast` on beat 30, `err_short` pulse, `s_hdr_ready` high afterward.
- Long payload, length 24 with 8 payload bytes: 24 output beats, `tlast` on beat 24, `err_long` pulse, remaining 4 bytes consumed with no output.
- `s_length = 10` with 5 payload bytes: no output beats, `err_bad_length` pulse, 5 bytes drained. Separately, `s_length = 20`: 20-byte header only, `tlast` on byte 19.
- Reset asserted during HEADER byte 7: `m_axis_tvalid` goes 0 at once; after release, a fresh golden frame is produced correctly.
